// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell adds a WIDTH-bit operand pair LSB first,
// one bit per clock, under a start/ready/busy/done handshake.

module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_cout;
  logic             accept, last_bit;

  fulladd u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift registers are few flops, not a RAM, so they take the reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      sum_sh <= '0;
      carry  <= Cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      carry  <= fa_cout;
      cnt    <= cnt + CW'(1);
    end
  end

  // Result registers only move on the final bit, so they hold through the next RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S    <= '0;
      Cout <= 1'b0;
    end else if (last_bit) begin
      S    <= {fa_s, sum_sh[WIDTH-1:1]};
      Cout <= fa_cout;
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: WIDTH=8 and WIDTH=4 instances,
// directed and random adds compared against plain integer addition.

module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] s8;

  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ready4, busy4, done4, cout4;
  logic [3:0] s4;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; all sampling and driving happens here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_sum(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    longint unsigned t = longint'(a) + longint'(b) + longint'(cin);
    return 64'(t & ((64'd1 << w) - 1));
  endfunction

  function automatic logic ref_cout(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin);
    longint unsigned t = longint'(a) + longint'(b) + longint'(cin);
    return t[w];
  endfunction

  // One complete add on the selected instance, checking handshake, hold and latency.
  task automatic do_add(input bit sel4, input logic [31:0] a, input logic [31:0] b, input logic cin);
    int w = sel4 ? 4 : 8;
    int n = 0;
    logic [7:0] prev_s;
    logic prev_c;
    prev_s = sel4 ? {4'h0, s4} : s8;
    prev_c = sel4 ? cout4 : cout8;
    check("ready_before_start", sel4 ? ready4 : ready8, 1);
    if (sel4) begin a4 = a[3:0]; b4 = b[3:0]; cin4 = cin; start4 = 1'b1; end
    else      begin a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; start8 = 1'b1; end
    cyc();
    start4 = 1'b0; start8 = 1'b0;
    // Operand changes after acceptance must have no effect.
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    while (!(sel4 ? done4 : done8) && n < w + 5) begin
      check("busy_in_run", sel4 ? busy4 : busy8, 1);
      check("s_hold_in_run", sel4 ? {4'h0, s4} : s8, prev_s);
      check("cout_hold_in_run", sel4 ? cout4 : cout8, prev_c);
      cyc();
      n++;
    end
    check("done_latency", n, w);
    check("sum", sel4 ? {4'h0, s4} : s8, ref_sum(w, a, b, cin));
    check("cout", sel4 ? cout4 : cout8, ref_cout(w, a, b, cin));
    cyc();
    check("done_one_cycle", sel4 ? done4 : done8, 0);
    check("ready_after_done", sel4 ? ready4 : ready8, 1);
  endtask

  initial begin
    int dones;
    int last;
    logic [7:0] cap_a, cap_b;
    logic cap_c;

    // Reset state
    #2;
    check("rst_ready", ready8, 1);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_s", s8, 0);
    check("rst_cout", cout8, 0);
    check("rst_ready4", ready4, 1);
    cyc();
    rst = 1'b0;
    cyc();
    check("idle_ready", ready8, 1);

    // Directed adds
    do_add(0, 32'h12, 32'h34, 1'b0);
    do_add(0, 32'hFF, 32'h01, 1'b0);
    do_add(0, 32'h5A, 32'hA5, 1'b1);
    do_add(0, 32'h0F, 32'h70, 1'b0);

    // Starts while busy or in the done cycle are ignored
    cap_a = 8'h3C; cap_b = 8'h21; cap_c = 1'b0;
    a8 = cap_a; b8 = cap_b; cin8 = cap_c; start8 = 1'b1;
    cyc();
    start8 = 1'b0;
    dones = 0;
    for (int i = 1; i <= 20; i++) begin
      start8 = (i == 3 || i == 8 || i == 9);
      a8 = 8'h77 + 8'(i); b8 = 8'h11; cin8 = 1'b1;
      cyc();
      if (done8) dones++;
    end
    start8 = 1'b0;
    check("ignored_starts_one_done", dones, 1);
    check("ignored_starts_sum", s8, ref_sum(8, cap_a, cap_b, cap_c));
    check("ignored_starts_cout", cout8, ref_cout(8, cap_a, cap_b, cap_c));
    check("ignored_starts_idle", ready8, 1);

    // Asynchronous reset mid-RUN at bit 4
    a8 = 8'hC3; b8 = 8'h5E; cin8 = 1'b1; start8 = 1'b1;
    cyc();
    start8 = 1'b0;
    repeat (4) cyc();
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_s", s8, 0);
    check("async_rst_cout", cout8, 0);
    check("async_rst_busy", busy8, 0);
    check("async_rst_ready", ready8, 1);
    check("async_rst_done", done8, 0);
    cyc();
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      cyc();
      if (done8) dones++;
    end
    check("no_done_after_abort", dones, 0);
    do_add(0, 32'h80, 32'h80, 1'b0);

    // start held high: one add every WIDTH+2 cycles
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    dones = 0;
    last = -1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (done8) begin
        dones++;
        check("held_sum", s8, 8'h03);
        check("held_cout", cout8, 0);
        if (last >= 0) check("held_spacing", i - last, 10);
        last = i;
      end
    end
    start8 = 1'b0;
    check("held_done_count", dones, 4);
    for (int i = 0; i < 20 && !ready8; i++) cyc();
    check("held_drain_ready", ready8, 1);

    // Random adds on both widths
    for (int i = 0; i < 12; i++)
      do_add(0, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));

    check("w4_reset_idle", ready4, 1);
    do_add(1, 32'hF, 32'hF, 1'b1);
    for (int i = 0; i < 6; i++)
      do_add(1, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
